// File: rtl/lsb_queue_param.sv
// In-order load/store queue: dispatch capture with CDB snooping, commit-gated stores,
// a single outstanding memory request issued from the head, and load extension on completion.
module lsb_queue_param #(
  parameter int DEPTH   = 16,
  parameter int XLEN    = 32,
  parameter int TAG_W   = 5,
  parameter int NUM_CDB = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     dispatch_valid,
  input  logic                     dispatch_is_store,
  input  logic [2:0]               dispatch_funct3,
  input  logic [XLEN-1:0]          dispatch_imm,
  input  logic                     dispatch_qj_busy,
  input  logic [TAG_W-1:0]         dispatch_qj,
  input  logic [XLEN-1:0]          dispatch_vj,
  input  logic                     dispatch_qk_busy,
  input  logic [TAG_W-1:0]         dispatch_qk,
  input  logic [XLEN-1:0]          dispatch_vk,
  input  logic [TAG_W-1:0]         dispatch_tag,
  output logic                     lsb_full,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]  cdb_value,
  input  logic                     commit_valid,
  input  logic [TAG_W-1:0]         commit_tag,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [XLEN-1:0]          mem_addr,
  output logic [XLEN-1:0]          mem_wdata,
  output logic [1:0]               mem_size,
  input  logic                     mem_ack,
  input  logic [XLEN-1:0]          mem_rdata,
  output logic                     out_valid,
  output logic [XLEN-1:0]          out_value,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Entry storage: payload fields and status flags.
  logic             is_store_q  [DEPTH];
  logic             is_store_d  [DEPTH];
  logic [2:0]       funct3_q    [DEPTH];
  logic [2:0]       funct3_d    [DEPTH];
  logic [XLEN-1:0]  imm_q       [DEPTH];
  logic [XLEN-1:0]  imm_d       [DEPTH];
  logic             qj_busy_q   [DEPTH];
  logic             qj_busy_d   [DEPTH];
  logic [TAG_W-1:0] qj_q        [DEPTH];
  logic [TAG_W-1:0] qj_d        [DEPTH];
  logic [XLEN-1:0]  vj_q        [DEPTH];
  logic [XLEN-1:0]  vj_d        [DEPTH];
  logic             qk_busy_q   [DEPTH];
  logic             qk_busy_d   [DEPTH];
  logic [TAG_W-1:0] qk_q        [DEPTH];
  logic [TAG_W-1:0] qk_d        [DEPTH];
  logic [XLEN-1:0]  vk_q        [DEPTH];
  logic [XLEN-1:0]  vk_d        [DEPTH];
  logic [TAG_W-1:0] tag_q       [DEPTH];
  logic [TAG_W-1:0] tag_d       [DEPTH];
  logic             committed_q [DEPTH];
  logic             committed_d [DEPTH];

  // CDB lookup results: {hit, value} per entry operand and for the incoming dispatch.
  logic [XLEN:0] qj_lk [DEPTH];
  logic [XLEN:0] qk_lk [DEPTH];
  logic [XLEN:0] dj_lk;
  logic [XLEN:0] dk_lk;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [0:0]       state_q, state_d;

  logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [XLEN-1:0]  mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0]       mem_size_q, mem_size_d;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_value_q, out_value_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic head_ready, do_enq, do_issue, do_done;

  function automatic logic [XLEN:0] cdb_lookup(
    input logic [TAG_W-1:0]         t,
    input logic [NUM_CDB-1:0]       v,
    input logic [NUM_CDB*TAG_W-1:0] tags,
    input logic [NUM_CDB*XLEN-1:0]  vals
  );
    logic [XLEN:0] r;
    r = '0;
    // Scan from the highest channel down so the lowest matching channel is the one left in r.
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (v[c] && tags[c*TAG_W +: TAG_W] == t) r = {1'b1, vals[c*XLEN +: XLEN]};
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [XLEN-1:0] raw);
    logic [XLEN-1:0] r;
    case (f3)
      3'b000:  r = {{(XLEN-8){raw[7]}}, raw[7:0]};
      3'b001:  r = {{(XLEN-16){raw[15]}}, raw[15:0]};
      3'b100:  r = {{(XLEN-8){1'b0}}, raw[7:0]};
      3'b101:  r = {{(XLEN-16){1'b0}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] store_align(input logic [2:0] f3, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    case (f3[1:0])
      2'b00:   r = {{(XLEN-8){1'b0}}, d[7:0]};
      2'b01:   r = {{(XLEN-16){1'b0}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] access_size(input logic [2:0] f3);
    logic [1:0] r;
    case (f3[1:0])
      2'b00:   r = 2'd0;
      2'b01:   r = 2'd1;
      default: r = 2'd2;
    endcase
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      qj_lk[i] = cdb_lookup(qj_q[i], cdb_valid, cdb_tag, cdb_value);
      qk_lk[i] = cdb_lookup(qk_q[i], cdb_valid, cdb_tag, cdb_value);
    end
    dj_lk = cdb_lookup(dispatch_qj, cdb_valid, cdb_tag, cdb_value);
    dk_lk = cdb_lookup(dispatch_qk, cdb_valid, cdb_tag, cdb_value);
  end

  assign lsb_full   = (count_q == CNT_W'(DEPTH));
  assign head_ready = (state_q == ST_IDLE) && (count_q != '0) && !qj_busy_q[head_q] &&
                      (!is_store_q[head_q] || (!qk_busy_q[head_q] && committed_q[head_q]));
  assign do_enq     = rdy && !flush && dispatch_valid && !lsb_full;
  assign do_issue   = rdy && !flush && head_ready;
  assign do_done    = rdy && !flush && (state_q == ST_WAIT) && mem_ack;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    imm_d       = imm_q;
    qj_busy_d   = qj_busy_q;
    qj_d        = qj_q;
    vj_d        = vj_q;
    qk_busy_d   = qk_busy_q;
    qk_d        = qk_q;
    vk_d        = vk_q;
    tag_d       = tag_q;
    committed_d = committed_q;
    if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (qj_busy_q[i] && qj_lk[i][XLEN]) begin
          qj_busy_d[i] = 1'b0;
          vj_d[i]      = qj_lk[i][XLEN-1:0];
        end
        if (qk_busy_q[i] && qk_lk[i][XLEN]) begin
          qk_busy_d[i] = 1'b0;
          vk_d[i]      = qk_lk[i][XLEN-1:0];
        end
        if (commit_valid && commit_tag == tag_q[i]) committed_d[i] = 1'b1;
      end
    end
    // The enqueue write lands after the snoop loop so a stale slot never keeps old flags.
    if (do_enq) begin
      is_store_d[tail_q]  = dispatch_is_store;
      funct3_d[tail_q]    = dispatch_funct3;
      imm_d[tail_q]       = dispatch_imm;
      qj_d[tail_q]        = dispatch_qj;
      qk_d[tail_q]        = dispatch_qk;
      tag_d[tail_q]       = dispatch_tag;
      qj_busy_d[tail_q]   = dispatch_qj_busy && !dj_lk[XLEN];
      vj_d[tail_q]        = (dispatch_qj_busy && dj_lk[XLEN]) ? dj_lk[XLEN-1:0] : dispatch_vj;
      qk_busy_d[tail_q]   = dispatch_qk_busy && !dk_lk[XLEN];
      vk_d[tail_q]        = (dispatch_qk_busy && dk_lk[XLEN]) ? dk_lk[XLEN-1:0] : dispatch_vk;
      committed_d[tail_q] = commit_valid && (commit_tag == dispatch_tag);
    end
  end

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    out_tag_d   = out_tag_q;
    if (flush) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      state_d     = ST_IDLE;
      mem_req_d   = 1'b0;
      out_valid_d = 1'b0;
    end else if (rdy) begin
      out_valid_d = 1'b0;
      if (do_enq) tail_d = tail_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_enq) - CNT_W'(do_done);
      if (do_issue) begin
        mem_req_d   = 1'b1;
        mem_we_d    = is_store_q[head_q];
        mem_addr_d  = vj_q[head_q] + imm_q[head_q];
        mem_wdata_d = store_align(funct3_q[head_q], vk_q[head_q]);
        mem_size_d  = access_size(funct3_q[head_q]);
        state_d     = ST_WAIT;
      end
      if (do_done) begin
        mem_req_d   = 1'b0;
        out_valid_d = 1'b1;
        out_tag_d   = tag_q[head_q];
        out_value_d = is_store_q[head_q] ? '0 : load_extend(funct3_q[head_q], mem_rdata);
        head_d      = head_q + PTR_W'(1);
        state_d     = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_tag_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        qj_busy_q[i]   <= 1'b0;
        qk_busy_q[i]   <= 1'b0;
        committed_q[i] <= 1'b0;
      end
    end else begin
      // NOTE: state registers use non-blocking assignment so all updates see pre-edge values.
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_tag_q   <= out_tag_d;
      qj_busy_q   <= qj_busy_d;
      qk_busy_q   <= qk_busy_d;
      committed_q <= committed_d;
    end
  end

  // NOTE: payload storage is not reset; an entry is only read once count covers it and it was written on enqueue.
  always_ff @(posedge clk) begin
    is_store_q <= is_store_d;
    funct3_q   <= funct3_d;
    imm_q      <= imm_d;
    qj_q       <= qj_d;
    vj_q       <= vj_d;
    qk_q       <= qk_d;
    vk_q       <= vk_d;
    tag_q      <= tag_d;
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_size  = mem_size_q;
  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_lsb_queue_param.sv
// Directed bench for lsb_queue_param: queue-based reference model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_lsb_queue_param;
  localparam int DEPTH   = 16;
  localparam int XLEN    = 32;
  localparam int TAG_W   = 5;
  localparam int NUM_CDB = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     rdy = 1'b1;
  logic                     flush = 1'b0;
  logic                     dispatch_valid = 1'b0;
  logic                     dispatch_is_store = 1'b0;
  logic [2:0]               dispatch_funct3 = '0;
  logic [XLEN-1:0]          dispatch_imm = '0;
  logic                     dispatch_qj_busy = 1'b0;
  logic [TAG_W-1:0]         dispatch_qj = '0;
  logic [XLEN-1:0]          dispatch_vj = '0;
  logic                     dispatch_qk_busy = 1'b0;
  logic [TAG_W-1:0]         dispatch_qk = '0;
  logic [XLEN-1:0]          dispatch_vk = '0;
  logic [TAG_W-1:0]         dispatch_tag = '0;
  logic                     lsb_full;
  logic [NUM_CDB-1:0]       cdb_valid = '0;
  logic [NUM_CDB*TAG_W-1:0] cdb_tag = '0;
  logic [NUM_CDB*XLEN-1:0]  cdb_value = '0;
  logic                     commit_valid = 1'b0;
  logic [TAG_W-1:0]         commit_tag = '0;
  logic                     mem_req, mem_we;
  logic [XLEN-1:0]          mem_addr, mem_wdata;
  logic [1:0]               mem_size;
  logic                     mem_ack = 1'b0;
  logic [XLEN-1:0]          mem_rdata = '0;
  logic                     out_valid;
  logic [XLEN-1:0]          out_value;
  logic [TAG_W-1:0]         out_tag;

  always #5 clk = ~clk;

  lsb_queue_param #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_is_store(dispatch_is_store),
    .dispatch_funct3(dispatch_funct3), .dispatch_imm(dispatch_imm),
    .dispatch_qj_busy(dispatch_qj_busy), .dispatch_qj(dispatch_qj), .dispatch_vj(dispatch_vj),
    .dispatch_qk_busy(dispatch_qk_busy), .dispatch_qk(dispatch_qk), .dispatch_vk(dispatch_vk),
    .dispatch_tag(dispatch_tag), .lsb_full(lsb_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_value(out_value), .out_tag(out_tag)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic             is_store;
    logic [2:0]       f3;
    logic [31:0]      imm;
    logic             qj_busy;
    logic [4:0]       qj;
    logic [31:0]      vj;
    logic             qk_busy;
    logic [4:0]       qk;
    logic [31:0]      vk;
    logic [4:0]       tag;
    logic             committed;
  } ent_t;

  ent_t        mq[$];
  bit          m_wait;
  logic        e_req, e_we, e_ov;
  logic [31:0] e_addr, e_wdata, e_val;
  logic [1:0]  e_size;
  logic [4:0]  e_tag;

  function automatic bit m_cdb(input logic [4:0] t, output logic [31:0] val);
    for (int c = 0; c < NUM_CDB; c++) begin
      if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == t) begin
        val = cdb_value[c*XLEN +: XLEN];
        return 1'b1;
      end
    end
    val = '0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [31:0] raw);
    longint unsigned nbytes, v;
    nbytes = 64'd1 << f3[1:0];
    if (nbytes >= 4) return raw;
    v = raw % (64'd1 << (8 * nbytes));
    if (!f3[2] && v >= (64'd1 << (8 * nbytes - 1))) v = v + (64'd1 << 32) - (64'd1 << (8 * nbytes));
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    longint unsigned nbytes;
    nbytes = 64'd1 << f3[1:0];
    if (nbytes >= 4) return d;
    return 32'(d % (64'd1 << (8 * nbytes)));
  endfunction

  task automatic model_reset();
    mq.delete();
    m_wait = 0;
    e_req = 0; e_we = 0; e_ov = 0;
    e_addr = '0; e_wdata = '0; e_val = '0; e_size = '0; e_tag = '0;
  endtask

  task automatic model_step();
    bit          pop;
    logic [31:0] v;
    ent_t        e;
    if (flush) begin
      mq.delete();
      m_wait = 0; e_req = 0; e_ov = 0;
      return;
    end
    if (!rdy) return;
    e_ov = 0;
    pop  = 0;
    if (m_wait && mem_ack) begin
      e_ov   = 1;
      e_tag  = mq[0].tag;
      e_val  = mq[0].is_store ? 32'h0 : m_ext(mq[0].f3, mem_rdata);
      e_req  = 0;
      m_wait = 0;
      pop    = 1;
    end else if (!m_wait && mq.size() > 0 && !mq[0].qj_busy &&
                 (!mq[0].is_store || (!mq[0].qk_busy && mq[0].committed))) begin
      e_req   = 1;
      e_we    = mq[0].is_store;
      e_addr  = mq[0].vj + mq[0].imm;
      e_size  = (mq[0].f3[1:0] == 2'd0) ? 2'd0 : (mq[0].f3[1:0] == 2'd1) ? 2'd1 : 2'd2;
      e_wdata = m_wdata(mq[0].f3, mq[0].vk);
      m_wait  = 1;
    end
    foreach (mq[i]) begin
      if (mq[i].qj_busy && m_cdb(mq[i].qj, v)) begin mq[i].qj_busy = 0; mq[i].vj = v; end
      if (mq[i].qk_busy && m_cdb(mq[i].qk, v)) begin mq[i].qk_busy = 0; mq[i].vk = v; end
      if (commit_valid && commit_tag == mq[i].tag) mq[i].committed = 1;
    end
    if (dispatch_valid && mq.size() < DEPTH) begin
      e.is_store = dispatch_is_store;
      e.f3 = dispatch_funct3; e.imm = dispatch_imm; e.tag = dispatch_tag;
      e.qj = dispatch_qj; e.qk = dispatch_qk;
      e.qj_busy = dispatch_qj_busy; e.vj = dispatch_vj;
      e.qk_busy = dispatch_qk_busy; e.vk = dispatch_vk;
      if (e.qj_busy && m_cdb(e.qj, v)) begin e.qj_busy = 0; e.vj = v; end
      if (e.qk_busy && m_cdb(e.qk, v)) begin e.qk_busy = 0; e.vk = v; end
      e.committed = commit_valid && commit_tag == dispatch_tag;
      mq.push_back(e);
    end
    if (pop) void'(mq.pop_front());
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // Per-cycle comparison, sampled 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      check("cyc_mem_req", mem_req, e_req);
      check("cyc_out_valid", out_valid, e_ov);
      check("cyc_lsb_full", lsb_full, mq.size() == DEPTH);
      if (e_req) begin
        check("cyc_mem_we", mem_we, e_we);
        check("cyc_mem_addr", mem_addr, e_addr);
        check("cyc_mem_size", mem_size, e_size);
        if (e_we) check("cyc_mem_wdata", mem_wdata, e_wdata);
      end
      if (e_ov) begin
        check("cyc_out_value", out_value, e_val);
        check("cyc_out_tag", out_tag, e_tag);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    dispatch_valid = 0; cdb_valid = '0; commit_valid = 0; mem_ack = 0; flush = 0;
  endtask

  task automatic drive_disp(input logic st, input logic [2:0] f3, input logic [31:0] imm,
                            input logic qjb, input logic [4:0] qj, input logic [31:0] vj,
                            input logic qkb, input logic [4:0] qk, input logic [31:0] vk,
                            input logic [4:0] tag);
    dispatch_valid = 1; dispatch_is_store = st; dispatch_funct3 = f3; dispatch_imm = imm;
    dispatch_qj_busy = qjb; dispatch_qj = qj; dispatch_vj = vj;
    dispatch_qk_busy = qkb; dispatch_qk = qk; dispatch_vk = vk; dispatch_tag = tag;
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] vj, input logic [31:0] imm, input logic [4:0] tag);
    drive_disp(1'b0, f3, imm, 1'b0, 5'd0, vj, 1'b0, 5'd0, 32'h0, tag);
    step();
  endtask

  // Waits (bounded) for mem_req; checks cycles from call to mem_req; returns at a falling edge.
  task automatic wait_req(input string name, input int exp_lat);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!mem_req && n < 20);
    check({name, "_req"}, mem_req, 1'b1);
    if (exp_lat > 0) check({name, "_lat"}, n, exp_lat);
    @(negedge clk);
  endtask

  task automatic ack(input logic [31:0] rdata);
    mem_ack = 1; mem_rdata = rdata;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "timeout");
  end

  logic [4:0]  exp_tag;
  logic [31:0] exp_addr;

  initial begin
    #1 rst = 0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_lsb_full", lsb_full, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_out_value", out_value, 0);
    rst = 1;
    step();

    // 1: ready LW 0x100+4
    load(3'b010, 32'h100, 32'h4, 5'd1);
    wait_req("t1", 1);
    check("t1_addr", mem_addr, 32'h104);
    check("t1_size", mem_size, 2);
    check("t1_we", mem_we, 0);
    ack(32'h8000_0001);
    check("t1_ov", out_valid, 1);
    check("t1_val", out_value, 32'h8000_0001);
    check("t1_tag", out_tag, 1);

    // 2: extension
    load(3'b000, 32'h40, 32'h0, 5'd2);
    wait_req("t2_lb", 1);
    check("t2_lb_size", mem_size, 0);
    ack(32'h80);
    check("t2_lb_val", out_value, 32'hFFFF_FF80);
    load(3'b100, 32'h40, 32'h0, 5'd4);
    wait_req("t2_lbu", 1);
    ack(32'h80);
    check("t2_lbu_val", out_value, 32'h0000_0080);
    load(3'b001, 32'h42, 32'h0, 5'd11);
    wait_req("t2_lh", 1);
    ack(32'h1234_8001);
    check("t2_lh_val", out_value, 32'hFFFF_8001);
    load(3'b101, 32'h42, 32'h0, 5'd12);
    wait_req("t2_lhu", 1);
    ack(32'hABCD_8001);
    check("t2_lhu_val", out_value, 32'h0000_8001);

    // 3: SW waits for commit
    drive_disp(1'b1, 3'b010, 32'h8, 1'b0, 5'd0, 32'h300, 1'b0, 5'd0, 32'hDEAD_BEEF, 5'd3);
    step();
    repeat (4) step();
    check("t3_hold", mem_req, 0);
    commit_valid = 1; commit_tag = 5'd3;
    step();
    wait_req("t3", 1);
    check("t3_we", mem_we, 1);
    check("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("t3_addr", mem_addr, 32'h308);
    ack(32'h0);
    check("t3_val", out_value, 0);
    check("t3_tag", out_tag, 3);
    // SB behind a load, committed while not at head
    load(3'b010, 32'h50, 32'h0, 5'd6);
    drive_disp(1'b1, 3'b000, 32'h1, 1'b0, 5'd0, 32'h500, 1'b0, 5'd0, 32'h1234_56AB, 5'd5);
    step();
    commit_valid = 1; commit_tag = 5'd5;
    step();
    ack(32'h77);
    check("t3_ld_tag", out_tag, 6);
    wait_req("t3_sb", 1);
    check("t3_sb_wdata", mem_wdata, 32'h0000_00AB);
    check("t3_sb_size", mem_size, 0);
    check("t3_sb_addr", mem_addr, 32'h501);
    ack(32'h0);
    check("t3_sb_tag", out_tag, 5);

    // 4: dispatch/CDB bypass on channel 1
    drive_disp(1'b0, 3'b010, 32'h10, 1'b1, 5'd7, 32'hDEAD, 1'b0, 5'd0, 32'h0, 5'd8);
    cdb_valid = 2'b11; cdb_tag = {5'd7, 5'd9}; cdb_value = {32'h200, 32'h999};
    step();
    wait_req("t4", 1);
    check("t4_addr", mem_addr, 32'h210);
    ack(32'h55);
    check("t4_tag", out_tag, 8);
    // lowest channel wins
    drive_disp(1'b0, 3'b010, 32'h4, 1'b1, 5'd12, 32'h0, 1'b0, 5'd0, 32'h0, 5'd10);
    step();
    repeat (2) step();
    check("t4b_hold", mem_req, 0);
    cdb_valid = 2'b11; cdb_tag = {5'd12, 5'd12}; cdb_value = {32'h500, 32'h400};
    step();
    wait_req("t4b", 1);
    check("t4b_addr", mem_addr, 32'h404);
    ack(32'h0);

    // 5: fill, overflow, pop under full, wrap
    for (int i = 0; i < DEPTH; i++) load(3'b010, 32'h1000 + 32'(4 * i), 32'h0, 5'(i));
    check("t5_full", lsb_full, 1);
    load(3'b010, 32'h3000, 32'h0, 5'd16);
    check("t5_full_17th", lsb_full, 1);
    drive_disp(1'b0, 3'b010, 32'h0, 1'b0, 5'd0, 32'h3000, 1'b0, 5'd0, 32'h0, 5'd20);
    ack(32'h0);
    check("t5_pop_tag", out_tag, 0);
    check("t5_after_pop", lsb_full, 0);
    load(3'b010, 32'h2000, 32'h0, 5'd17);
    check("t5_refull", lsb_full, 1);
    for (int k = 0; k < DEPTH; k++) begin
      exp_tag  = (k < DEPTH - 1) ? 5'(k + 1) : 5'd17;
      exp_addr = (k < DEPTH - 1) ? 32'h1000 + 32'(4 * (k + 1)) : 32'h2000;
      wait_req("t5_drain", 1);
      check("t5_drain_addr", mem_addr, exp_addr);
      ack(32'(k));
      check("t5_drain_tag", out_tag, exp_tag);
    end
    check("t5_empty", lsb_full, 0);

    // 6: flush in WAIT, late ack
    load(3'b010, 32'h600, 32'h0, 5'd21);
    wait_req("t6", 1);
    flush = 1;
    step();
    check("t6_req", mem_req, 0);
    check("t6_ov", out_valid, 0);
    mem_ack = 1;
    step();
    check("t6_late_ov", out_valid, 0);
    load(3'b010, 32'h700, 32'h0, 5'd22);
    wait_req("t6_new", 1);
    check("t6_new_addr", mem_addr, 32'h700);
    flush = 1; mem_ack = 1;
    step();
    check("t6_flush_ack_ov", out_valid, 0);
    check("t6_flush_ack_req", mem_req, 0);
    drive_disp(1'b0, 3'b010, 32'h0, 1'b0, 5'd0, 32'h800, 1'b0, 5'd0, 32'h0, 5'd23);
    flush = 1;
    step();
    repeat (3) step();
    check("t6_flush_disp", mem_req, 0);
    // async reset mid-request
    load(3'b010, 32'h880, 32'h0, 5'd24);
    wait_req("t6_rst", 1);
    #2 rst = 0;
    #1;
    check("t6_rst_req", mem_req, 0);
    check("t6_rst_addr", mem_addr, 0);
    check("t6_rst_ov", out_valid, 0);
    check("t6_rst_tag", out_tag, 0);
    check("t6_rst_full", lsb_full, 0);
    @(negedge clk);
    rst = 1;
    step();
    load(3'b010, 32'h900, 32'h0, 5'd25);
    wait_req("t6_post", 1);
    check("t6_post_addr", mem_addr, 32'h900);
    ack(32'h1);
    check("t6_post_tag", out_tag, 25);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
